// File: rtl/fifo_drain_serializer.sv
// Read-side FIFO consumer: pops one word at a time and shifts it out
// bit-serially on a valid/ready link.
module fifo_drain_serializer #(
  parameter int W         = 4,
  parameter int CNT_W     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [W-1:0]     fifo_data,
  output logic             fifo_rd_en,
  input  logic             ser_ready,
  output logic             ser_valid,
  output logic             ser_data,
  output logic             ser_last,
  output logic             busy,
  output logic [CNT_W-1:0] word_count
);

  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam logic [BW-1:0] LAST = BW'(W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    word_count_d = word_count_q;
    fifo_rd_en   = 1'b0;
    ser_valid    = 1'b0;
    ser_data     = 1'b0;
    ser_last     = 1'b0;
    unique case (state_q)
      IDLE: begin
        fifo_rd_en = !fifo_empty;
        if (!fifo_empty) state_d = FETCH;
      end
      FETCH: begin
        shreg_d   = fifo_data;
        bit_cnt_d = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_data  = MSB_FIRST ? shreg_q[W-1] : shreg_q[0];
        ser_last  = (bit_cnt_q == LAST);
        if (ser_ready) begin
          shreg_d   = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == LAST) begin
            word_count_d = word_count_q + CNT_W'(1);
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // no pop may be issued in the cycle reset is applied
    if (rst) fifo_rd_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      word_count_q <= word_count_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign word_count = word_count_q;

endmodule
